lp_input_event_detector: RTL and testbench

Front end of the low-power calculator: synchronizes the raw operand and opcode inputs, debounces them, and latches a settled operand set. It raises `event_detected` toward the power-control FSM and holds it until that FSM acknowledges with `compute_en`. It runs on the ungated `clk`, so it stays awake while the datapath sleeps.

---
 rtl/lp_calc_pkg.sv | 10 +
 rtl/lp_sync2.sv | 20 ++
 rtl/lp_input_event_detector.sv | 82 ++++++++
 tb/tb_lp_input_event_detector.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/lp_calc_pkg.sv
// lp_calc_pkg: shared encodings and defaults for the low-power calculator
package lp_calc_pkg;
  typedef enum logic {DET_STABLE = 1'b0, DET_DEBOUNCE = 1'b1} det_state_t;
  typedef enum logic [1:0] {PWR_SLEEP = 2'd0, PWR_ACTIVE = 2'd1, PWR_IDLE = 2'd2} pwr_state_t;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
endpackage

// File: rtl/lp_sync2.sv
// lp_sync2: parameterized-width two-flop synchronizer with sync active-low reset
module lp_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  // two-stage capture of the asynchronous vector
  always_ff @(posedge clk)
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/lp_input_event_detector.sv
// lp_input_event_detector: synchronize, debounce and latch operands, flag new events
module lp_input_event_detector
  import lp_calc_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int OP_W            = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [OP_W-1:0]   op_in,
  input  logic              compute_en,
  output logic              event_detected,
  output logic [DATA_W-1:0] a_q,
  output logic [DATA_W-1:0] b_q,
  output logic [OP_W-1:0]   op_q,
  output logic              overrun
);
  localparam int VW = 2*DATA_W + OP_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  det_state_t state, state_d;
  logic [VW-1:0] s, stable_q, stable_d, cand, cand_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic pend, pend_d, ovr, ovr_d, commit;
  lp_sync2 #(.W(VW)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({a_in, b_in, op_in}),
    .q       (s)
  );
  // debounce FSM next state; a commit outranks a same-cycle acknowledge
  always_comb begin
    state_d  = state;
    stable_d = stable_q;
    cand_d   = cand;
    cnt_d    = cnt;
    commit   = 1'b0;
    if (state == DET_STABLE) begin
      if (s != stable_q) begin
        cand_d  = s;
        cnt_d   = '0;
        state_d = DET_DEBOUNCE;
      end
    end else if (s == stable_q) begin
      state_d = DET_STABLE;
    end else if (s != cand) begin
      cand_d = s;
      cnt_d  = '0;
    end else if (cnt == LAST) begin
      commit   = 1'b1;
      stable_d = cand;
      state_d  = DET_STABLE;
    end else begin
      cnt_d = cnt + 1'b1;
    end
    pend_d = commit | (pend & ~compute_en);
    ovr_d  = ovr | (commit & pend);
  end
  // state and operand registers
  always_ff @(posedge clk)
    if (!reset_n) begin
      state    <= DET_STABLE;
      stable_q <= '0;
      cand     <= '0;
      cnt      <= '0;
      pend     <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      state    <= state_d;
      stable_q <= stable_d;
      cand     <= cand_d;
      cnt      <= cnt_d;
      pend     <= pend_d;
      ovr      <= ovr_d;
    end
  assign {a_q, b_q, op_q} = stable_q;
  assign event_detected   = pend;
  assign overrun          = ovr;
endmodule

// File: tb/tb_lp_input_event_detector.sv
// tb_lp_input_event_detector: scoreboard bench for the input event detector
module tb_lp_input_event_detector;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       ovr;
    int         cyc;
  } exp_t;
  logic clk = 1'b0, reset_n = 1'b0, compute_en = 1'b0;
  logic [7:0] a_in = '0, b_in = '0, a_q, b_q;
  logic [1:0] op_in = '0, op_q;
  logic event_detected, overrun;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic ev_p = 1'b0;
  logic [17:0] ops_p = '0;
  lp_input_event_detector dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .a_in           (a_in),
    .b_in           (b_in),
    .op_in          (op_in),
    .compute_en     (compute_en),
    .event_detected (event_detected),
    .a_q            (a_q),
    .b_q            (b_q),
    .op_q           (op_q),
    .overrun        (overrun)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // monitor: every new event (rise, or operand overwrite while pending) pops one expectation
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    if (event_detected && (!ev_p || {a_q, b_q, op_q} != ops_p)) begin
      if (sb.size() == 0) check("spurious_event", 1, 0);
      else begin
        e = sb.pop_front();
        check("ev_a", a_q, e.a);
        check("ev_b", b_q, e.b);
        check("ev_op", op_q, e.op);
        check("ev_ovr", overrun, e.ovr);
        check("ev_cycle", cyc, e.cyc);
      end
    end
    ev_p = event_detected;
    ops_p = {a_q, b_q, op_q};
  end
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input logic ovr);
    @(negedge clk);
    a_in = a;
    b_in = b;
    op_in = op;
    sb.push_back('{a, b, op, ovr, cyc + 7});
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    sb.delete();
  endtask
  task automatic ack();
    @(negedge clk);
    compute_en = 1'b1;
    @(negedge clk);
    compute_en = 1'b0;
    check("ack_clears", event_detected, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_ev", event_detected, 0);
    check("rst_ops", {a_q, b_q, op_q}, 0);
    check("rst_ovr", overrun, 0);
    reset_n = 1'b1;
    apply(8'h12, 8'h34, 2'd1, 1'b0);
    drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_pending", event_detected, 1);
    end
    ack();
    apply(8'h00, 8'h34, 2'd1, 1'b0);
    drain();
    ack();
    @(negedge clk);
    a_in = 8'h01;
    repeat (2) @(negedge clk);
    a_in = 8'h00;
    repeat (12) @(negedge clk);
    check("glitch_ev", event_detected, 0);
    check("glitch_a", a_q, 8'h00);
    @(negedge clk);
    a_in = 8'h05;
    @(negedge clk);
    a_in = 8'h07;
    @(negedge clk);
    a_in = 8'h05;
    apply(8'h07, 8'h34, 2'd1, 1'b0);
    drain();
    ack();
    apply(8'hAA, 8'h34, 2'd1, 1'b0);
    drain();
    apply(8'hBB, 8'h34, 2'd1, 1'b1);
    drain();
    check("ovr_a", a_q, 8'hBB);
    check("ovr_flag", overrun, 1);
    check("ovr_ev", event_detected, 1);
    ack();
    apply(8'hCC, 8'h34, 2'd1, 1'b1);
    repeat (6) @(negedge clk);
    compute_en = 1'b1;
    @(negedge clk);
    compute_en = 1'b0;
    check("coincident_ev", event_detected, 1);
    @(negedge clk);
    check("coincident_hold", event_detected, 1);
    drain();
    ack();
    @(negedge clk);
    a_in = 8'h33;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ev", event_detected, 0);
    check("mid_rst_ops", {a_q, b_q, op_q}, 0);
    check("mid_rst_ovr", overrun, 0);
    reset_n = 1'b1;
    sb.push_back('{8'h33, 8'h34, 2'd1, 1'b0, cyc + 7});
    drain();
    check("final_a", a_q, 8'h33);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
